// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with occupancy count, threshold flags and flush.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags with an err_clr input.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_BITS = 4,
    parameter int unsigned AF_THRESH  = 12,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full_flag,
    output logic                  empty_flag,
    output logic                  almost_full,
    output logic                  almost_empty,
`ifdef SYNC_FIFO_ERR_EN
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr,
`endif
    output logic [DEPTH_BITS:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam int unsigned PTR_W = DEPTH_BITS + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;

    assign wr_acc = wr_en & ~full_flag;
    assign rd_acc = rd_en & ~empty_flag;

    // Pointer update; the MSB is the wrap bit that separates full from empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (rst && !flush && wr_acc) begin
            mem[wr_ptr[DEPTH_BITS-1:0]] <= wr_data;
        end
    end

    assign count        = wr_ptr - rd_ptr;
    assign empty_flag   = (wr_ptr == rd_ptr);
    assign full_flag    = (wr_ptr[DEPTH_BITS-1:0] == rd_ptr[DEPTH_BITS-1:0]) &&
                          (wr_ptr[DEPTH_BITS] != rd_ptr[DEPTH_BITS]);
    assign almost_full  = (count >= PTR_W'(AF_THRESH));
    assign almost_empty = (count <= PTR_W'(AE_THRESH));
    assign rd_data      = empty_flag ? '0 : mem[rd_ptr[DEPTH_BITS-1:0]];

`ifdef SYNC_FIFO_ERR_EN
    // Sticky error flags; a new error wins over a simultaneous clear, flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full_flag) overflow <= 1'b1;
            else if (err_clr)       overflow <= 1'b0;
            if (rd_en && empty_flag) underflow <= 1'b1;
            else if (err_clr)        underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param at default parameters (DEPTH=16, AF=12, AE=2).
// Error-flag checks are compiled in when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       full_flag;
    logic       empty_flag;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic       overflow;
    logic       underflow;
    logic       err_clr = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sync_fifo_param dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .full_flag    (full_flag),
        .empty_flag   (empty_flag),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef SYNC_FIFO_ERR_EN
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr),
`endif
        .count        (count)
    );

    typedef struct {
        logic       r;
        logic       fl;
        logic       we;
        logic [7:0] wd;
        logic       re;
        logic [4:0] cnt;
        logic       e;
        logic       f;
        logic       ae;
        logic       af;
        logic [7:0] rdd;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic fl, input logic we,
                        input logic [7:0] wd, input logic re);
        rst = r; flush = fl; wr_en = we; wr_data = wd; rd_en = re;
        @(posedge clk);
        #1;
        rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    // Flags follow from occupancy at default thresholds.
    task automatic chk_state(input string tag, input int ecnt, input logic [7:0] erd);
        chk({tag, ".count"}, 32'(count), 32'(ecnt));
        chk({tag, ".empty"}, 32'(empty_flag), 32'(ecnt == 0));
        chk({tag, ".full"},  32'(full_flag),  32'(ecnt == 16));
        chk({tag, ".ae"},    32'(almost_empty), 32'(ecnt <= 2));
        chk({tag, ".af"},    32'(almost_full),  32'(ecnt >= 12));
        chk({tag, ".rd"},    32'(rd_data), 32'(erd));
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0;
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h55};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h11};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h22};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};

        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Random traffic, then two reset cycles.
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, 1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));
        step(1'b0, 1'b0, 1'b1, 8'hAB, 1'b1);
        chk_state("rst1", 0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_state("rst2", 0, 8'h00);
`ifdef SYNC_FIFO_ERR_EN
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.unf", 32'(underflow), 32'd0);
`endif

        for (int v = 0; v < 14; v++) begin
            step(tbl[v].r, tbl[v].fl, tbl[v].we, tbl[v].wd, tbl[v].re);
            chk($sformatf("tbl%0d.count", v), 32'(count), 32'(tbl[v].cnt));
            chk($sformatf("tbl%0d.empty", v), 32'(empty_flag), 32'(tbl[v].e));
            chk($sformatf("tbl%0d.full", v), 32'(full_flag), 32'(tbl[v].f));
            chk($sformatf("tbl%0d.ae", v), 32'(almost_empty), 32'(tbl[v].ae));
            chk($sformatf("tbl%0d.af", v), 32'(almost_full), 32'(tbl[v].af));
            chk($sformatf("tbl%0d.rd", v), 32'(rd_data), 32'(tbl[v].rdd));
        end

        // Fill 0x00..0x0F, drop a 17th write, drain in order.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(i), 1'b0);
            chk_state($sformatf("fill%0d", i), i + 1, 8'h00);
        end
        step(1'b1, 1'b0, 1'b1, 8'hAA, 1'b0);
        chk_state("fill_ovf", 16, 8'h00);
`ifdef SYNC_FIFO_ERR_EN
        chk("fill.ovf", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        err_clr = 1'b0;
        chk("clr.ovf", 32'(overflow), 32'd0);
`endif
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            chk_state($sformatf("drain%0d", i), 15 - i, (i < 15) ? 8'(i + 1) : 8'h00);
        end

        // Wrap-around: 10 in/out, then a full pass of 16.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(8'hA0 + i), 1'b0);
            chk_state($sformatf("wa%0d", i), i + 1, 8'hA0);
        end
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            chk_state($sformatf("wb%0d", i), 9 - i, (i < 9) ? 8'(8'hA1 + i) : 8'h00);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
            chk_state($sformatf("wc%0d", i), i + 1, 8'h20);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            chk_state($sformatf("wd%0d", i), 15 - i, (i < 15) ? 8'(8'h21 + i) : 8'h00);
        end

        // Simultaneous read/write at count=5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
        chk_state("sim_pre", 5, 8'h40);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 1'b1, 8'(8'h45 + k), 1'b1);
            chk_state($sformatf("sim%0d", k), 5, 8'(8'h41 + k));
        end
        for (int j = 0; j < 5; j++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            chk_state($sformatf("simd%0d", j), 4 - j, (j < 4) ? 8'(8'h45 + j) : 8'h00);
        end

        // Simultaneous read/write at full: write dropped.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h60 + i), 1'b0);
        chk_state("fullsim_pre", 16, 8'h60);
        step(1'b1, 1'b0, 1'b1, 8'hEE, 1'b1);
        chk_state("fullsim", 15, 8'h61);
        for (int j = 0; j < 15; j++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
            chk_state($sformatf("fulld%0d", j), 14 - j, (j < 14) ? 8'(8'h62 + j) : 8'h00);
        end

        // Underflow attempt, then flush at count=7 with a write in the same cycle.
        step(1'b1, 1'b0, 1'b1, 8'h55, 1'b1);
        chk_state("esim", 1, 8'h55);
`ifdef SYNC_FIFO_ERR_EN
        chk("esim.unf", 32'(underflow), 32'd1);
`endif
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h70 + i), 1'b0);
        chk_state("fl_pre", 7, 8'h55);
        step(1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
        chk_state("flush", 0, 8'h00);
`ifdef SYNC_FIFO_ERR_EN
        chk("flush.unf", 32'(underflow), 32'd1);
`endif
        step(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
        chk_state("fl_wr", 1, 8'h3C);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_state("fl_rd", 0, 8'h00);

        // Reset mid-burst at count=9.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'h89, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_state("mb_pre", 9, 8'h81);
        step(1'b0, 1'b0, 1'b1, 8'h8A, 1'b1);
        chk_state("mb_rst", 0, 8'h00);
`ifdef SYNC_FIFO_ERR_EN
        chk("mb.unf", 32'(underflow), 32'd0);
`endif
        step(1'b1, 1'b0, 1'b1, 8'h3C, 1'b0);
        chk_state("mb_wr", 1, 8'h3C);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_state("mb_rd", 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
